// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if: request/response bus between the CPU controller and the memory responder
interface mc_mem_responder_if #(parameter int DATA_W = 32);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              err;
  modport master (output req, we, addr, wdata, input busy, ready, rdata, err);
  modport slave  (input req, we, addr, wdata, output busy, ready, rdata, err);
endinterface

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word memory answering req/ready with WAIT_CYCLES wait states.
// Define MEM_ALIGN_CHECK_EN to flag misaligned byte addresses through err.
module mc_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input logic               clk,
  input logic               reset,
  mc_mem_responder_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [DATA_W-1:0]    mem [2**ADDR_BITS];
  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d, ready_q, ready_d, err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 we_q, we_d, mis_q, mis_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 accept, enter_resp, mis_in, mem_we;
  logic                 unused;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in = bus.addr[1:0] != 2'b00;
  assign unused = ^bus.addr[31:ADDR_BITS+2];
`else
  assign mis_in = 1'b0;
  assign unused = ^{bus.addr[31:ADDR_BITS+2], bus.addr[1:0]};
`endif

  assign accept     = state_q == S_IDLE && bus.req;
  // with zero wait states the accepting edge is also the RESP-entry edge, so use the live command
  assign enter_resp = (accept && WAIT_INIT == 4'd0) || (state_q == S_BUSY && cnt_q == 4'd1);

  always_comb begin
    we_d    = accept ? bus.we : we_q;
    idx_d   = accept ? bus.addr[ADDR_BITS+1:2] : idx_q;
    wdata_d = accept ? bus.wdata : wdata_q;
    mis_d   = accept ? mis_in : mis_q;
    state_d = enter_resp ? S_RESP : accept ? S_BUSY : state_q == S_RESP ? S_IDLE : state_q;
    cnt_d   = accept ? WAIT_INIT : state_q == S_BUSY ? cnt_q - 4'd1 : cnt_q;
    busy_d  = state_d != S_IDLE;
    ready_d = enter_resp;
    err_d   = enter_resp && mis_d;
    rdata_d = !enter_resp ? rdata_q : mis_d ? '0 : we_d ? rdata_q : mem[idx_d];
    mem_we  = enter_resp && we_d && !mis_d && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    mis_q   <= mis_d;
    if (mem_we) mem[idx_d] <= wdata_d;
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Word-addressed data/instruction memory that answers the multicycle CPU controller's memory requests.
- Uses a req/ready handshake with a programmable number of wait states, so the controller's MEM and IF states can be exercised against realistic latency.
- Holds a local word array. Reads return data on completion; writes commit on completion.
- Sits between the CPU datapath address/data registers and storage.

Parameters:
- ADDR_BITS, 10: word-index width; DEPTH = 2**ADDR_BITS words.
- WAIT_CYCLES, 2: busy cycles between acceptance and response; legal range 0..15.
- DATA_W, 32: word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; latched with req.
- addr  input  32  byte address; word index = addr[ADDR_BITS+1:2]; upper bits ignored.
- wdata  input  DATA_W  write data; latched with req.
- busy  output  1  high while a transaction is in flight (BUSY or RESP).
- ready  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read data; valid only while ready=1 on a read.
- err  output  1  alignment error flag, qualified by ready.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - BUSY: counting wait states.
  - RESP: one cycle, completion.
- All outputs are registered.
- Reset (sync, reset=1 at a clk edge) forces:
  - state=IDLE, busy=0, ready=0, rdata=0, err=0, wait counter=0.
  - Memory array contents are NOT reset.
- IDLE, req=1 at edge N:
  - Latch we, word index, wdata.
  - Load counter with WAIT_CYCLES.
  - busy=1 from cycle N+1.
  - If WAIT_CYCLES=0, go straight to RESP; otherwise go to BUSY.
- IDLE, req=0: stay in IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - When counter==1 at an edge, go to RESP.
  - Total cycles spent in BUSY = WAIT_CYCLES.
- Entry to RESP, on the same edge:
  - Write: mem[idx] <= latched wdata.
  - Read: rdata <= mem[idx].
  - ready=1 for exactly that one RESP cycle.
- Latency: request accepted at edge N → ready high during cycle N+WAIT_CYCLES+1.
- RESP → IDLE unconditionally. ready and busy return to 0.
- rdata:
  - Holds its last value after RESP.
  - Not updated on writes.
  - Consumers must qualify it with ready.
- req during BUSY/RESP: ignored. Not queued, no error.
- If req is still high in the first IDLE cycle after RESP, it is a new request.
  - The requester must drop req in the cycle after it sees ready, unless it intends back-to-back operation.
  - Back-to-back throughput = one transaction per WAIT_CYCLES+2 cycles.
- Latched command is stable: changes on we/addr/wdata after acceptance have no effect.
- Read of a word in the same RESP cycle as its write cannot occur (single port). A read following a write returns the new data.
- Reset in BUSY: transaction aborted, no write committed, no ready pulse.
- Reset in RESP: the write has already committed at the RESP-entry edge; ready is forced to 0 in the next cycle.
- Address wrap: indices beyond DEPTH alias via truncation of addr[31:ADDR_BITS+2].

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - addr[1:0] != 0 at acceptance sets a latched misaligned flag.
  - The transaction still takes full latency.
  - In RESP: err=1, no write performed, rdata <= 0.
  - Aligned accesses give err=0.
- Undefined:
  - addr[1:0] are ignored; the access uses the truncated word index.
  - err is constant 0.
  - The port exists in both builds.

Test Plan:
- Reset, then idle 5 cycles → busy=0, ready=0, rdata=0, err=0 throughout.
- WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF at edge N → ready only in cycle N+3. Then read addr=0x10 → rdata=0xDEADBEEF with ready, exactly 3 cycles after acceptance.
- WAIT_CYCLES=0: read addr=0x4 after writing 0x12345678 → ready in the cycle after acceptance, rdata=0x12345678. Holding req high gives a transaction every 2 cycles.
- Toggle req, we, addr, wdata randomly during BUSY → ignored. Original transaction completes with its latched data; no extra ready pulses.
- Assert reset in the second BUSY cycle of a write of 0xCAFEF00D to addr=0x20 → no ready. A subsequent read of 0x20 returns the prior contents.
- With MEM_ALIGN_CHECK_EN: write addr=0x22 → ready with err=1. Word 0x20 is unchanged and rdata=0. Without the macro, the same write lands in word 0x20 and err=0.
